// File: rtl/pow2_recombiner.sv
// Multi-cycle recombiner: rebuilds M = Q*2^N + R by shifting Q left one bit per
// clock and then merging in the low N bits of R. Flags lost Q bits and oversized R.
module pow2_recombiner #(
  parameter int W  = 16,
  parameter int NW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [W-1:0]  q_in,
  input  logic [W-1:0]  r_in,
  input  logic [NW-1:0] n_in,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  m_out,
  output logic          ovf,
  output logic          rem_err
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;

  // Handshake: start is sampled only while idle; done pulses for one cycle with
  // m_out/ovf/rem_err valid, and busy drops on that same edge.

  logic [1:0]    state;
  logic [W-1:0]  acc;
  logic [W-1:0]  r_lat;
  logic [NW-1:0] cnt;
  logic [W-1:0]  mask;

  // Bits [n_in-1:0] set; all zero when n_in is 0.
  always_comb begin
    mask = (W'(1) << n_in) - W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      acc     <= '0;
      r_lat   <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      m_out   <= '0;
      ovf     <= 1'b0;
      rem_err <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            acc     <= q_in;
            cnt     <= n_in;
            r_lat   <= r_in & mask;
            rem_err <= |(r_in & ~mask);
            ovf     <= 1'b0;
            busy    <= 1'b1;
            state   <= (n_in != '0) ? SHIFT : FINISH;
          end
        end
        SHIFT: begin
          acc <= {acc[W-2:0], 1'b0};
          ovf <= ovf | acc[W-1];
          cnt <= cnt - NW'(1);
          if (cnt == NW'(1)) begin
            state <= FINISH;
          end
        end
        FINISH: begin
          // r_lat lives entirely below bit N where acc is zero, so OR is the sum.
          m_out <= acc | r_lat;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/pow2_recombiner.md
Name: pow2_recombiner

Overview:
Multi-cycle inverse of the power-of-two divider. It rebuilds the dividend as M = Q*2^N + R from a quotient Q, remainder R and shift amount N. It shifts Q left one bit per clock, then merges in R. It sits after the divider so that divider plus recombiner forms a round-trip path. It flags lost high bits and remainders that are out of range.

Parameters:
W, 16, data width of Q, R and M
NW, 4, width of the shift amount N (max shift 2^NW-1)

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only when busy=0
q_in  input  W  quotient Q
r_in  input  W  remainder R
n_in  input  NW  shift amount N
busy  output  1  operation in progress
done  output  1  one-cycle pulse; m_out and flags valid
m_out  output  W  reconstructed value, held until the next done
ovf  output  1  a 1 bit was shifted out of the MSB of Q (result truncated)
rem_err  output  1  R has a set bit at position >= N, i.e. R >= 2^N

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE. busy=0, done=0, m_out=0, ovf=0, rem_err=0. Internal acc, r_lat and cnt are cleared.
- Reset mid-operation aborts the operation. No done pulse occurs and outputs return to their reset values.
- States: IDLE, SHIFT, FINISH.
- IDLE, with start=1 sampled at edge E0:
  - acc<=q_in, cnt<=n_in.
  - r_lat<=r_in & mask, where mask=(1<<n_in)-1 (bits [n_in-1:0]; mask=0 when n_in=0).
  - rem_err<=|(r_in & ~mask).
  - ovf<=0, busy<=1.
  - Next state: SHIFT if n_in!=0, otherwise FINISH.
- SHIFT, each edge:
  - acc<=acc<<1 (LSB filled with 0).
  - ovf<=ovf|acc[W-1].
  - cnt<=cnt-1.
  - When cnt==1 at that edge, next state is FINISH. Exactly N shift edges occur.
- FINISH, one edge: m_out<=acc|r_lat, done<=1, busy<=0, state<=IDLE.
- done is high for exactly one cycle and is cleared at the following edge.
- Latency: done and m_out update at edge E0+N+1.
  - busy is high from E0 through E0+N+1; it falls on the same edge done rises.
  - N=0 gives done at E0+1.
- start while busy=1 is ignored; no queuing.
- start on the edge where done rises (state is FINISH) is ignored. A new start is accepted from the next edge, at the earliest in the cycle where done=1.
- Arithmetic is modulo 2^W.
  - Bits of Q shifted past W-1 are discarded and set ovf.
  - R bits at positions >= N are dropped from m_out and set rem_err.
  - Since r_lat only occupies bits below N and acc has zeros there, OR equals ADD.
- ovf and rem_err are valid with done and hold until the next accepted start clears or reloads them.
- Input ports are only sampled at E0; later changes to them have no effect.

Test Plan:
- Q=0x0123, R=0x0005, N=4 -> done at E0+5, m_out=0x1235, ovf=0, rem_err=0; busy high for edges E0..E0+4 exactly.
- Q=0xBEEF, R=0x0000, N=0 -> done at E0+1, m_out=0xBEEF, flags 0. Repeat with R=0x0001 -> m_out=0xBEEF, rem_err=1.
- Q=0x0003, R=0x7FFF, N=15 -> done at E0+16, m_out=0xFFFF, ovf=1, rem_err=0. Q=0x0001, R=0x0000, N=15 -> m_out=0x8000, ovf=0.
- Start Q=0x0001, N=8, then pulse start with Q=0xFFFF, N=1 at E0+3 -> second request ignored; done at E0+9 with m_out=0x0100. Back-to-back start asserted in the done cycle -> accepted.
- Assert rst at E0+2 of an N=10 operation -> no done pulse, all outputs 0 next cycle; a fresh start afterwards completes normally.
- Round-trip: 1000 random M and N through the divider (Q,R) into this block -> m_out==M, ovf=0, rem_err=0 every time.
